// File: rtl/ppu_job_sched.sv
// ppu_job_sched: sequences one PPU job. Latches a job descriptor, pulls
// 16-lane partial-sum vectors from the MAC array, presents each to the PPU
// for VALID_HOLD cycles, waits for the PPU result under a watchdog and
// writes the 128-bit result to consecutive output SRAM addresses.
// Optional build macro PPU_JOB_SCHED_PERF_EN adds perf_cycles/perf_stall.
module ppu_job_sched #(
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8,
    parameter int VALID_HOLD = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [383:0]      in_psum,
    input  logic [7:0]        in_scale,
    input  logic [7:0]        in_bias,
    output logic              ppu_valid,
    output logic [383:0]      ppu_psum,
    output logic [7:0]        ppu_scale,
    output logic [7:0]        ppu_bias,
    input  logic              ppu_done,
    input  logic [127:0]      ppu_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [127:0]      wr_data,
    output logic              busy,
    output logic              job_done,
    output logic              err_timeout
`ifdef PPU_JOB_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    // Counter widths sized so the terminal value (N-1) always fits.
    localparam int HOLD_W = (VALID_HOLD > 1) ? $clog2(VALID_HOLD) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(VALID_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    logic [2:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [CNT_W-1:0]  rem_q,      rem_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [TO_W-1:0]   to_q,       to_d;
    logic              done_lat_q, done_lat_d;
    logic [127:0]      data_q,     data_d;
    logic [383:0]      psum_q,     psum_d;
    logic [7:0]        scale_q,    scale_d;
    logic [7:0]        bias_q,     bias_d;
    logic              err_q,      err_d;
    logic              busy_q,     busy_d;
    logic              in_ready_q, in_ready_d;
    logic              pvalid_q,   pvalid_d;
    logic              wr_en_q,    wr_en_d;
    logic              jdone_q,    jdone_d;

    // Next-state, datapath and registered status flags (decoded from next state).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        to_d       = to_q;
        done_lat_d = done_lat_q;
        data_d     = data_q;
        psum_d     = psum_q;
        scale_d    = scale_q;
        bias_d     = bias_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = num_vec;
                    err_d  = 1'b0;
                    if (num_vec == CNT_W'(0)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    psum_d     = in_psum;
                    scale_d    = in_scale;
                    bias_d     = in_bias;
                    hold_d     = HOLD_W'(0);
                    done_lat_d = 1'b0;
                    state_d    = S_ISSUE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_ISSUE: begin
                // An early (single-cycle) done carries its data now; keep both.
                if (ppu_done && !done_lat_q) begin
                    done_lat_d = 1'b1;
                    data_d     = ppu_data;
                end else begin
                    done_lat_d = done_lat_q;
                end
                if (hold_q == HOLD_LAST) begin
                    to_d    = TO_W'(0);
                    state_d = S_WAIT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_WAIT: begin
                if (done_lat_q) begin
                    done_lat_d = 1'b0;
                    state_d    = S_WRITE;
                end else if (ppu_done) begin
                    data_d  = ppu_data;
                    state_d = S_WRITE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_FETCH);
        pvalid_d   = (state_d == S_ISSUE);
        wr_en_d    = (state_d == S_WRITE);
        jdone_d    = (state_d == S_FINISH);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            to_q       <= '0;
            done_lat_q <= 1'b0;
            data_q     <= '0;
            psum_q     <= '0;
            scale_q    <= 8'h00;
            bias_q     <= 8'h00;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            pvalid_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            jdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            to_q       <= to_d;
            done_lat_q <= done_lat_d;
            data_q     <= data_d;
            psum_q     <= psum_d;
            scale_q    <= scale_d;
            bias_q     <= bias_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
            pvalid_q   <= pvalid_d;
            wr_en_q    <= wr_en_d;
            jdone_q    <= jdone_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign ppu_valid   = pvalid_q;
    assign ppu_psum    = psum_q;
    assign ppu_scale   = scale_q;
    assign ppu_bias    = bias_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign busy        = busy_q;
    assign job_done    = jdone_q;
    assign err_timeout = err_q;

`ifdef PPU_JOB_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    // Busy-cycle and fetch-stall counters; cleared on an accepted start.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                perf_cycles_d = 32'd0;
                perf_stall_d  = 32'd0;
            end else begin
                perf_cycles_d = perf_cycles_q;
            end
        end else begin
            perf_cycles_d = perf_cycles_q + 32'd1;
            if ((state_q == S_FETCH) && !in_valid) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end else begin
                perf_stall_d = perf_stall_q;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`else
    // Build without performance counters: no extra state.
`endif

endmodule

// File: tb/tb_ppu_job_sched.sv
// Directed self-checking bench for ppu_job_sched (default parameters).
module tb_ppu_job_sched;

    logic         clk;
    logic         rst;
    logic         start;
    logic [9:0]   base_addr;
    logic [7:0]   num_vec;
    logic         in_valid;
    logic         in_ready;
    logic [383:0] in_psum;
    logic [7:0]   in_scale;
    logic [7:0]   in_bias;
    logic         ppu_valid;
    logic [383:0] ppu_psum;
    logic [7:0]   ppu_scale;
    logic [7:0]   ppu_bias;
    logic         ppu_done;
    logic [127:0] ppu_data;
    logic         wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic         busy;
    logic         job_done;
    logic         err_timeout;
`ifdef PPU_JOB_SCHED_PERF_EN
    logic [31:0]  perf_cycles;
    logic [31:0]  perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ppu_job_sched dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_vec(num_vec), .in_valid(in_valid), .in_ready(in_ready),
        .in_psum(in_psum), .in_scale(in_scale), .in_bias(in_bias),
        .ppu_valid(ppu_valid), .ppu_psum(ppu_psum), .ppu_scale(ppu_scale),
        .ppu_bias(ppu_bias), .ppu_done(ppu_done), .ppu_data(ppu_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .job_done(job_done), .err_timeout(err_timeout)
`ifdef PPU_JOB_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [9:0] b, input logic [7:0] n);
        base_addr = b;
        num_vec   = n;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    // One vector: gap idle FETCH cycles, hand over the vector, PPU returns
    // done on cycle d (cycle 0 = first ISSUE cycle), expect one write.
    task automatic vec(input string tag, input logic [9:0] exp_addr, input int d,
                       input logic [127:0] dat, input logic [383:0] ps,
                       input logic [7:0] sc, input logic [7:0] bi, input int gap);
        int wr_c;
        int vcount;
        logic rdy_bad;
        logic [9:0] got_addr;
        logic [127:0] got_data;
        wr_c = -1; vcount = 0; rdy_bad = 1'b0;
        got_addr = 10'h000; got_data = 128'h0;
        for (int g = 0; g < gap; g++) begin
            if (!in_ready) rdy_bad = 1'b1;
            in_valid = 1'b0;
            cyc();
        end
        chk({tag, "_in_ready_fetch"}, {383'h0, in_ready}, 384'h1);
        in_valid = 1'b1; in_psum = ps; in_scale = sc; in_bias = bi;
        cyc();
        in_valid = 1'b0; in_psum = ~ps; in_scale = ~sc; in_bias = ~bi;
        chk({tag, "_psum"}, ppu_psum, ps);
        chk({tag, "_scale_bias"}, {368'h0, ppu_scale, ppu_bias}, {368'h0, sc, bi});
        for (int c = 0; c < 100 && wr_c < 0; c++) begin
            if (ppu_valid) vcount++;
            if (in_ready) rdy_bad = 1'b1;
            if (wr_en) begin
                wr_c = c; got_addr = wr_addr; got_data = wr_data;
            end
            ppu_done = (c == d);
            ppu_data = (c == d) ? dat : ~dat;
            cyc();
        end
        ppu_done = 1'b0;
        chki({tag, "_write_cycle"}, wr_c, (d < 5) ? 6 : d + 1);
        chki({tag, "_valid_cycles"}, vcount, 5);
        chk({tag, "_wr_addr"}, {374'h0, got_addr}, {374'h0, exp_addr});
        chk({tag, "_wr_data"}, {256'h0, got_data}, {256'h0, dat});
        chk({tag, "_in_ready_only_fetch"}, {383'h0, rdy_bad}, 384'h0);
    endtask

    logic [383:0] ps1;
    int err_c;
    logic jd_at_err;
    logic wr_seen;
    logic pv_seen;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 10'h000; num_vec = 8'h00;
        in_valid = 1'b0; in_psum = 384'h0; in_scale = 8'h00; in_bias = 8'h00;
        ppu_done = 1'b0; ppu_data = 128'h0;
        for (int i = 0; i < 16; i++) ps1[i*24 +: 24] = (i < 8) ? 24'd15008 : 24'd129794;
        cyc(); cyc();

        // Reset state
        chk("reset_ctrl", {370'h0, busy, in_ready, ppu_valid, wr_en, job_done,
                           err_timeout, ppu_scale, ppu_bias}, 384'h0);
        chk("reset_wr", {246'h0, wr_addr, wr_data}, 384'h0);
        chk("reset_psum", ppu_psum, 384'h0);
        rst = 1'b0;
        cyc();

        // Single vector, done during ISSUE (latched)
        start_job(10'h010, 8'd1);
        chk("t1_busy", {383'h0, busy}, 384'h1);
        vec("t1", 10'h010, 2, {16{8'hA5}}, ps1, 8'h65, 8'h01, 0);
        chk("t1_job_done", {383'h0, job_done}, 384'h1);
        cyc();
        chk("t1_idle", {382'h0, busy, job_done}, 384'h0);

        // Four vectors across the address wrap, gapped input
        start_job(10'h3FE, 8'd4);
        vec("t2a", 10'h3FE, 7, 128'h1111_2222_3333_4444_5555_6666_7777_8888, {16{24'h000001}}, 8'h10, 8'h20, 2);
        vec("t2b", 10'h3FF, 7, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, {16{24'h123456}}, 8'h11, 8'h21, 2);
        vec("t2c", 10'h000, 7, 128'hDEAD_BEEF_0000_FFFF_CAFE_F00D_1234_5678, {16{24'hABCDEF}}, 8'h12, 8'h22, 2);
        vec("t2d", 10'h001, 7, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, {16{24'h7FFFFF}}, 8'h13, 8'h23, 2);
        chk("t2_job_done", {383'h0, job_done}, 384'h1);
        cyc();

        // Zero-length job
        start_job(10'h055, 8'd0);
        chk("t3_finish", {380'h0, job_done, busy, ppu_valid, wr_en}, {380'h0, 4'b1100});
        cyc();
        chk("t3_idle", {380'h0, job_done, busy, ppu_valid, wr_en}, 384'h0);

        // PPU never answers: watchdog
        start_job(10'h020, 8'd1);
        in_valid = 1'b1; in_psum = ps1; in_scale = 8'h01; in_bias = 8'h02;
        cyc();
        in_valid = 1'b0;
        err_c = -1; jd_at_err = 1'b0; wr_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wr_en) wr_seen = 1'b1;
            if (err_timeout) begin
                err_c = c; jd_at_err = job_done;
                break;
            end
            cyc();
        end
        chki("t4_err_cycle", err_c, 5 + 64);
        chk("t4_job_done", {383'h0, jd_at_err}, 384'h1);
        chk("t4_no_write", {383'h0, wr_seen}, 384'h0);
        cyc();
        chk("t4_sticky", {382'h0, err_timeout, busy}, {382'h0, 2'b10});
        start_job(10'h000, 8'd0);
        chk("t4_cleared", {383'h0, err_timeout}, 384'h0);
        cyc();

        // start and ppu_done while busy are ignored
        start_job(10'h040, 8'd2);
        base_addr = 10'h200; num_vec = 8'd5; start = 1'b1; ppu_done = 1'b1;
        ppu_data = 128'hBAD0;
        cyc();
        start = 1'b0; ppu_done = 1'b0;
        vec("t6a", 10'h040, 6, 128'h0A0B_0C0D, {16{24'h000F0F}}, 8'h31, 8'h41, 0);
        vec("t6b", 10'h041, 6, 128'h0E0F_1011, {16{24'h00F0F0}}, 8'h32, 8'h42, 1);
        chk("t6_job_done", {383'h0, job_done}, 384'h1);
        cyc();
        chk("t6_idle", {383'h0, busy}, 384'h0);

        // Reset during WAIT of vector 2 of 3
        start_job(10'h100, 8'd3);
        vec("t5a", 10'h100, 6, 128'h5555, {16{24'h000555}}, 8'h51, 8'h61, 0);
        in_valid = 1'b1; in_psum = ps1; in_scale = 8'h77; in_bias = 8'h88;
        cyc();
        in_valid = 1'b0;
        wr_seen = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (wr_en) wr_seen = 1'b1;
            cyc();
        end
        pv_seen = ppu_valid;
        chk("t5_in_wait", {382'h0, busy, pv_seen}, {382'h0, 2'b10});
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_rst_ctrl", {370'h0, busy, in_ready, ppu_valid, wr_en, job_done,
                            err_timeout, ppu_scale, ppu_bias}, 384'h0);
        chk("t5_rst_wr", {246'h0, wr_addr, wr_data}, 384'h0);
        chk("t5_rst_psum", ppu_psum, 384'h0);
        ppu_done = 1'b1; ppu_data = 128'h9999;
        cyc();
        ppu_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (wr_en || busy) wr_seen = 1'b1;
            cyc();
        end
        chk("t5_no_write", {383'h0, wr_seen}, 384'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
